// File: rtl/amount_pkg.sv
// Shared definitions for the amount entry path and the display path.
package amount_pkg;

  localparam int unsigned DIGIT_W            = 4;
  localparam int unsigned VALUE_W            = 7;
  localparam int unsigned MAX_AMOUNT_DEFAULT = 59;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  typedef enum logic [2:0] {
    ST_EMPTY   = 3'd0,
    ST_ONE     = 3'd1,
    ST_TWO     = 3'd2,
    ST_CONVERT = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  // Two-digit BCD entry as shown on the display.
  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_entry_t;

  // tens*10 + ones without a multiplier: tens*8 + tens*2 + ones.
  function automatic logic [VALUE_W-1:0] bcd_to_bin(input bcd_entry_t d);
    return (VALUE_W'(d.tens) << 3) + (VALUE_W'(d.tens) << 1) + VALUE_W'(d.ones);
  endfunction

endpackage

// File: rtl/amount_entry_if.sv
// Keypad / controller / display bundle for amount_entry.
interface amount_entry_if #(
  parameter int unsigned WIDTH = 6
) ();

  logic             key_valid;
  logic [3:0]       key_code;
  logic             amount_ready;
  logic [WIDTH-1:0] amount;
  logic             amount_valid;
  logic [3:0]       disp_tens;
  logic [3:0]       disp_ones;
  logic             entry_err;

  // Keypad and controller side.
  modport master (
    output key_valid, key_code, amount_ready,
    input  amount, amount_valid, disp_tens, disp_ones, entry_err
  );

  // Entry block side.
  modport slave (
    input  key_valid, key_code, amount_ready,
    output amount, amount_valid, disp_tens, disp_ones, entry_err
  );

endinterface

// File: rtl/amount_entry_timer.sv
// Inactivity counter for a partial keypad entry.
module amount_entry_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Fires on the cycle the idle count reaches its limit with no key arriving.
  assign expire = run && !restart && (cnt == LAST);

  // Count idle cycles while running; any key or a stop returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || restart || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/amount_entry.sv
// Keypad-to-amount entry: two BCD digits -> binary amount under valid/ready.
// Optional inactivity timeout enabled by defining AMOUNT_ENTRY_TIMEOUT_EN.
module amount_entry
  import amount_pkg::*;
#(
  parameter int unsigned WIDTH          = 6,
  parameter int unsigned MAX_AMOUNT     = MAX_AMOUNT_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic           clk,
  input logic           rst_n,
  amount_entry_if.slave bus
);

  state_t             state_q, state_d;
  bcd_entry_t         digits_q, digits_d;
  logic [WIDTH-1:0]   amount_q, amount_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [VALUE_W-1:0] value;
  logic               key_digit, key_clear, key_enter;
  logic               expire;

  if (TIMEOUT_CYCLES == 0 || MAX_AMOUNT > 99 || MAX_AMOUNT >= (1 << WIDTH)) begin : g_bad_cfg
    $error("amount_entry: invalid WIDTH/MAX_AMOUNT/TIMEOUT_CYCLES combination");
  end

`ifdef AMOUNT_ENTRY_TIMEOUT_EN
  logic timer_run;
  assign timer_run = (state_q == ST_ONE) || (state_q == ST_TWO);

  amount_entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (timer_run),
    .restart (bus.key_valid),
    .expire  (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign key_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
  assign value     = bcd_to_bin(digits_q);

  assign bus.amount       = amount_q;
  assign bus.amount_valid = valid_q;
  assign bus.disp_tens    = digits_q.tens;
  assign bus.disp_ones    = digits_q.ones;
  assign bus.entry_err    = err_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      digits_q <= '0;
      amount_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      amount_q <= amount_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    amount_d = amount_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (key_clear) begin
          digits_d = '0;
        end else if (key_digit) begin
          digits_d.tens = '0;
          digits_d.ones = bus.key_code;
          state_d       = ST_ONE;
        end else if (key_enter) begin
          err_d = 1'b1;
        end
      end
      ST_ONE: begin
        if (key_clear || expire) begin
          digits_d = '0;
          state_d  = ST_EMPTY;
        end else if (key_digit) begin
          digits_d.tens = digits_q.ones;
          digits_d.ones = bus.key_code;
          state_d       = ST_TWO;
        end else if (key_enter) begin
          state_d = ST_CONVERT;
        end
      end
      ST_TWO: begin
        if (key_clear || expire) begin
          digits_d = '0;
          state_d  = ST_EMPTY;
        end else if (key_digit) begin
          err_d = 1'b1;
        end else if (key_enter) begin
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // Keys are not looked at during the single conversion cycle.
        if (value > VALUE_W'(MAX_AMOUNT)) begin
          err_d    = 1'b1;
          digits_d = '0;
          state_d  = ST_EMPTY;
        end else begin
          amount_d = WIDTH'(value);
          valid_d  = 1'b1;
          state_d  = ST_RESULT;
        end
      end
      ST_RESULT: begin
        // Transfer or abandon; amount itself keeps its last value.
        if (key_clear || bus.amount_ready) begin
          valid_d  = 1'b0;
          digits_d = '0;
          state_d  = ST_EMPTY;
        end
      end
      default: begin
        state_d  = ST_EMPTY;
        digits_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_amount_entry.sv
// Scoreboard bench for amount_entry: directed key sequences, expected
// transfers/errors queued at stimulus time and checked by a monitor.
module tb_amount_entry;
  import amount_pkg::*;

  localparam int unsigned WIDTH   = 6;
  localparam int unsigned MAX_AMT = 59;
  localparam int unsigned TMO     = 20;

  typedef struct {
    bit    is_err;
    int    amount;
    int    tens;
    int    ones;
    string name;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  amount_entry_if #(.WIDTH(WIDTH)) bus ();

  amount_entry #(
    .WIDTH          (WIDTH),
    .MAX_AMOUNT     (MAX_AMT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int code);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(code);
    tick(1);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask

  task automatic push_x(input string name, input int amt, input int t, input int o);
    exp_t x;
    x.is_err = 1'b0; x.amount = amt; x.tens = t; x.ones = o; x.name = name;
    q.push_back(x);
  endtask

  task automatic push_e(input string name, input int t, input int o);
    exp_t x;
    x.is_err = 1'b1; x.amount = 0; x.tens = t; x.ones = o; x.name = name;
    q.push_back(x);
  endtask

  task automatic chk_disp(input string name, input int t, input int o);
    chk({name, "_tens"}, int'(bus.disp_tens), t);
    chk({name, "_ones"}, int'(bus.disp_ones), o);
  endtask

  // Monitor: every error pulse or accepted transfer must match the queue head.
  always @(negedge clk) begin
    if (rst_n && (bus.entry_err || (bus.amount_valid && bus.amount_ready))) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got err=%0d valid=%0d amount=%0d, expected no event",
                 bus.entry_err, bus.amount_valid, bus.amount);
      end else begin
        e = q.pop_front();
        chk({e.name, "_is_err"}, int'(bus.entry_err), int'(e.is_err));
        if (!e.is_err) chk({e.name, "_amount"}, int'(bus.amount), e.amount);
        chk({e.name, "_tens"}, int'(bus.disp_tens), e.tens);
        chk({e.name, "_ones"}, int'(bus.disp_ones), e.ones);
      end
    end
  end

  initial begin
    bus.key_valid    = 1'b0;
    bus.key_code     = 4'd0;
    bus.amount_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", int'(bus.amount_valid), 0);
    chk("rst_amount", int'(bus.amount), 0);
    chk("rst_err", int'(bus.entry_err), 0);
    chk_disp("rst_disp", 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // 1,5,ENTER with ready high: valid exactly one cycle, two edges after ENTER
    bus.amount_ready = 1'b1;
    press(1);
    press(5);
    chk_disp("t1_disp", 1, 5);
    push_x("t1_xfer", 15, 1, 5);
    press(int'(KEY_ENTER));
    chk("t1_valid_convert", int'(bus.amount_valid), 0);
    tick(1);
    chk("t1_valid_high", int'(bus.amount_valid), 1);
    tick(1);
    chk("t1_valid_low", int'(bus.amount_valid), 0);
    chk_disp("t1_disp_after", 0, 0);

    // Single digit 7
    press(7);
    chk_disp("t2_disp", 0, 7);
    push_x("t2_xfer", 7, 0, 7);
    press(int'(KEY_ENTER));
    tick(3);

    // Boundary: 59 accepted
    press(5);
    press(9);
    push_x("t_max_xfer", 59, 5, 9);
    press(int'(KEY_ENTER));
    tick(3);

    // 60 rejected: one error, no valid, display cleared
    press(6);
    press(0);
    push_e("t3_reject", 0, 0);
    press(int'(KEY_ENTER));
    tick(2);
    chk("t3_valid", int'(bus.amount_valid), 0);
    chk_disp("t3_disp", 0, 0);

    // Third digit rejected, entry kept
    press(1);
    press(2);
    push_e("t4_third", 1, 2);
    press(3);
    tick(1);
    chk_disp("t4_disp", 1, 2);
    push_x("t4_xfer", 12, 1, 2);
    press(int'(KEY_ENTER));
    tick(3);

    // Controller stalls five cycles; digit during wait ignored silently
    bus.amount_ready = 1'b0;
    push_x("t5_xfer", 42, 4, 2);
    press(4);
    press(2);
    press(int'(KEY_ENTER));
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid_held", int'(bus.amount_valid), 1);
      chk("t5_amount_held", int'(bus.amount), 42);
      if (i == 2) press(9);
      else        tick(1);
    end
    bus.amount_ready = 1'b1;
    tick(1);
    chk("t5_valid_drop", int'(bus.amount_valid), 0);
    chk("t5_amount_kept", int'(bus.amount), 42);

    // Idle after one digit
    press(3);
    chk_disp("t6_disp_entry", 0, 3);
    tick(TMO + 5);
`ifdef AMOUNT_ENTRY_TIMEOUT_EN
    chk_disp("t6_disp_timeout", 0, 0);
`else
    chk_disp("t6_disp_persist", 0, 3);
`endif
    press(int'(KEY_CLEAR));
    chk_disp("t6_disp_clear", 0, 0);
    push_e("t6_enter_empty", 0, 0);
    press(int'(KEY_ENTER));
    tick(2);

    // CLEAR in RESULT abandons the value
    bus.amount_ready = 1'b0;
    press(8);
    press(int'(KEY_ENTER));
    tick(1);
    chk("t7_valid_before", int'(bus.amount_valid), 1);
    press(int'(KEY_CLEAR));
    chk("t7_valid_clear", int'(bus.amount_valid), 0);
    chk_disp("t7_disp_clear", 0, 0);
    tick(2);

    // Asynchronous reset while holding a result
    press(2);
    press(4);
    press(int'(KEY_ENTER));
    tick(1);
    chk("t8_valid_before", int'(bus.amount_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t8_valid_async", int'(bus.amount_valid), 0);
    chk("t8_amount_async", int'(bus.amount), 0);
    chk_disp("t8_disp_async", 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("t8_valid_after", int'(bus.amount_valid), 0);

    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
